// File: rtl/slot_pkg.sv
// Shared constants and debounce state encoding for the slot machine switch conditioning.
package slot_pkg;

  localparam int unsigned NUM_SW             = 3;
  localparam int unsigned DEF_TICK_DIV       = 6000;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 20;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchroniser, tick-driven debounce FSM with run counter,
// registered level and single-cycle press/release pulses.
module debounce_channel
  import slot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    sync;
  logic          s;
  deb_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level_c, press_c, release_c;

  assign s = ~sync[1];

  // Synchroniser idles released (high) out of reset.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], sw_n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      level         <= level_c;
      press_pulse   <= press_c;
      release_pulse <= release_c;
    end
  end

  // Counter holds the number of consecutive ticks disagreeing with the accepted state.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    press_c   = 1'b0;
    release_c = 1'b0;
    if (tick) begin
      case (state)
        RELEASED: begin
          if (s) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
              press_c  = 1'b1;
            end else begin
              state_nx = PRESS_PEND;
              cnt_nx   = CW'(1);
            end
          end
        end
        PRESS_PEND: begin
          if (!s) begin
            state_nx = RELEASED;
            cnt_nx   = '0;
          end else if (cnt + CW'(1) == CW'(DEBOUNCE_TICKS)) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
            press_c  = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_nx  = RELEASED;
              cnt_nx    = '0;
              release_c = 1'b1;
            end else begin
              state_nx = RELEASE_PEND;
              cnt_nx   = CW'(1);
            end
          end
        end
        RELEASE_PEND: begin
          if (s) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (cnt + CW'(1) == CW'(DEBOUNCE_TICKS)) begin
            state_nx  = RELEASED;
            cnt_nx    = '0;
            release_c = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end
      endcase
    end
    level_c = (state_nx == PRESSED) || (state_nx == RELEASE_PEND);
  end

endmodule

// File: rtl/slot_switch_debouncer.sv
// Conditions the three active-low slot machine push switches: shared sample tick
// generator feeding one debounce channel per switch.
module slot_switch_debouncer
  import slot_pkg::*;
#(
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic              mainClock,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_n,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_press,
  output logic [NUM_SW-1:0] sw_release
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  logic [TW-1:0] tcnt;
  logic          tick;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  // Free-running sample tick divider.
  always_ff @(posedge mainClock) begin
    if (reset)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TW'(1);
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_ch (
      .clk          (mainClock),
      .reset        (reset),
      .tick         (tick),
      .sw_n         (sw_n[i]),
      .level        (sw_level[i]),
      .press_pulse  (sw_press[i]),
      .release_pulse(sw_release[i])
    );
  end

endmodule

// File: tb/tb_slot_switch_debouncer.sv
// Self-checking bench for slot_switch_debouncer: directed scenarios plus random switch
// activity compared every cycle against a run-length debounce model.
module tb_slot_switch_debouncer;

  localparam int TD = 4;
  localparam int DT = 3;

  logic       clk;
  logic       reset;
  logic [2:0] sw_n;
  logic [2:0] sw_level, sw_press, sw_release;

  slot_switch_debouncer #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .mainClock (clk),
    .reset     (reset),
    .sw_n      (sw_n),
    .sw_level  (sw_level),
    .sw_press  (sw_press),
    .sw_release(sw_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit en       = 1'b0;

  // Model: accepted level flips after DT consecutive ticks whose sample disagrees with it.
  logic [2:0] m_s1, m_s2, m_level, m_press, m_rel;
  int         m_tc;
  int         m_cnt [3];
  logic [2:0] ms;
  bit         mtick;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_s1 = 3'b111; m_s2 = 3'b111; m_tc = 0;
      m_level = 3'b000; m_press = 3'b000; m_rel = 3'b000;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      ms    = ~m_s2;
      mtick = (m_tc == TD - 1);
      m_tc  = mtick ? 0 : m_tc + 1;
      m_s2  = m_s1;
      m_s1  = sw_n;
      m_press = 3'b000;
      m_rel   = 3'b000;
      if (mtick) begin
        for (int i = 0; i < 3; i++) begin
          if (ms[i] != m_level[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DT) begin
              m_cnt[i]   = 0;
              m_level[i] = ~m_level[i];
              if (m_level[i]) m_press[i] = 1'b1;
              else            m_rel[i]   = 1'b1;
            end
          end else begin
            m_cnt[i] = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected %0d..%0d", name, cyc, act, lo, hi);
    end
  endtask

  int np [3];
  int nr [3];

  always @(negedge clk) begin
    if (en) begin
      check("level_vs_model",   32'(sw_level),   32'(m_level));
      check("press_vs_model",   32'(sw_press),   32'(m_press));
      check("release_vs_model", 32'(sw_release), 32'(m_rel));
      for (int i = 0; i < 3; i++) begin
        if (sw_press[i] === 1'b1)   np[i]++;
        if (sw_release[i] === 1'b1) nr[i]++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      np[i] = 0;
      nr[i] = 0;
    end
  endtask

  // Waits (bounded) on a negedge where a selected press/release pulse is visible.
  task automatic wait_pulse(input string name, input logic [2:0] mask, input bit is_press,
                            input int maxc, output logic [2:0] seen);
    logic [2:0] v;
    seen = 3'b000;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      v = (is_press ? sw_press : sw_release) & mask;
      if (v != 3'b000) begin
        seen = is_press ? sw_press : sw_release;
        return;
      end
    end
    failures++;
    checks++;
    $display("FAIL %s timeout cycle=%0d got=none expected pulse mask=%0b", name, cyc, mask);
  endtask

  initial begin
    int         c0;
    logic [2:0] seen;
    bit         sampled;
    int         p;

    clear_counts();
    reset = 1'b1;
    sw_n  = 3'b000;
    step(1);
    en = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_outputs_zero", 32'({sw_level, sw_press, sw_release}), 32'd0);
    end
    step(1);
    reset = 1'b0;
    c0 = cyc;
    @(negedge clk);
    check("post_reset_outputs_zero", 32'({sw_level, sw_press, sw_release}), 32'd0);
    wait_pulse("first_press", 3'b111, 1'b1, 30, seen);
    check_range("first_press_latency", cyc - c0, 11, 15);
    check("first_press_all", 32'(seen), 32'h7);

    // Clean press and release on channel 0.
    step(1);
    sw_n = 3'b111;
    step(30);
    clear_counts();
    sw_n[0] = 1'b0;
    c0 = cyc;
    wait_pulse("clean_press", 3'b001, 1'b1, 30, seen);
    check_range("clean_press_latency", cyc - c0, 11, 15);
    check("clean_press_level", 32'(sw_level[0]), 32'd1);
    step(20);
    check("clean_press_count", 32'(np[0]), 32'd1);
    sw_n[0] = 1'b1;
    c0 = cyc;
    wait_pulse("clean_release", 3'b001, 1'b0, 30, seen);
    check_range("clean_release_latency", cyc - c0, 11, 15);
    check("clean_release_level", 32'(sw_level[0]), 32'd0);
    step(20);
    check("clean_release_count", 32'(nr[0]), 32'd1);
    check("clean_press_count_after", 32'(np[0]), 32'd1);

    // Bounce on channel 1, then settle pressed.
    clear_counts();
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) sw_n[1] = ~sw_n[1];
      step(1);
    end
    sw_n[1] = 1'b0;
    step(30);
    check("bounce_press_count", 32'(np[1]), 32'd1);
    check("bounce_release_count", 32'(nr[1]), 32'd0);
    check("bounce_level", 32'(sw_level[1]), 32'd1);
    sw_n[1] = 1'b1;
    step(30);

    // Single-cycle glitch on channel 2 aligned to be sampled on a tick.
    clear_counts();
    for (int k = 0; k < 8 && m_tc != 1; k++) step(1);
    sw_n[2] = 1'b0;
    step(1);
    sw_n[2] = 1'b1;
    sampled = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step(1);
      if (m_cnt[2] == 1) sampled = 1'b1;
    end
    check("glitch_sampled_on_tick", 32'(sampled), 32'd1);
    check("glitch_cnt_cleared", 32'(m_cnt[2]), 32'd0);
    check("glitch_press_count", 32'(np[2]), 32'd0);
    check("glitch_release_count", 32'(nr[2]), 32'd0);

    // Simultaneous press on all channels.
    sw_n = 3'b000;
    wait_pulse("simul_press", 3'b111, 1'b1, 30, seen);
    check("simul_press_vector", 32'(seen), 32'h7);
    check("simul_level", 32'(sw_level), 32'h7);
    step(1);
    sw_n = 3'b111;
    step(30);

    // Reset while channel 0 is mid-debounce with two agreeing samples.
    sw_n[0] = 1'b0;
    for (int k = 0; k < 30 && m_cnt[0] != 2; k++) step(1);
    clear_counts();
    reset = 1'b1;
    step(3);
    @(negedge clk);
    check("midreset_level", 32'(sw_level[0]), 32'd0);
    check("midreset_no_press", 32'(np[0]), 32'd0);
    step(1);
    reset = 1'b0;
    c0 = cyc;
    wait_pulse("midreset_repress", 3'b001, 1'b1, 30, seen);
    check_range("midreset_repress_latency", cyc - c0, 11, 15);
    step(10);
    check("midreset_press_count", 32'(np[0]), 32'd1);

    // Random activity with varying bounce densities and occasional resets.
    for (int phase = 0; phase < 4; phase++) begin
      p = (phase == 0) ? 2 : (phase == 1) ? 4 : (phase == 2) ? 16 : 64;
      for (int k = 0; k < 500; k++) begin
        for (int i = 0; i < 3; i++)
          if ($urandom_range(p - 1, 0) == 0) sw_n[i] = ~sw_n[i];
        reset = ($urandom_range(299, 0) == 0);
        step(1);
      end
    end
    reset = 1'b0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slot_switch_debouncer.md
# slot_switch_debouncer

Conditions the three raw, active-low, mechanical push switches of the slot machine before they reach the slot system: synchronises them to the 6 MHz main clock and debounces each one with a counter clocked by an internal 1 kHz sample tick. For each switch it produces a clean level and single-cycle press/release pulses. It sits directly upstream of the slot system's start/stop inputs and replaces the bare `~switch` inversion at the top level.

## Interface
- `TICK_DIV`, 6000: main-clock cycles per sample tick (1 kHz at 6 MHz); legal values ≥ 2.
- `DEBOUNCE_TICKS`, 20: consecutive disagreeing samples needed to accept a new switch state (20 ms); legal values ≥ 1.
- `mainClock` in 1: 6 MHz main clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `sw_n` in 3: raw switches, active-low (0 = pressed); asynchronous to `mainClock`.
- `sw_level` out 3: debounced state, 1 = pressed.
- `sw_press` out 3: one-`mainClock` pulse on each accepted press.
- `sw_release` out 3: one-`mainClock` pulse on each accepted release.

## Operation
- Synchroniser: 2-FF chain per bit on `sw_n`. Reset value is 1 (released). The synchronised value is inverted to active-high `s`.
- Tick generator: counter `tcnt` runs 0..`TICK_DIV`-1 and wraps to 0. `tick` = (`tcnt` == `TICK_DIV`-1), high for one cycle. Reset sets `tcnt` = 0.
- Per-channel FSM plus counter `cnt` (width clog2(`DEBOUNCE_TICKS`+1)). The FSM changes state only on `tick`.
  - RELEASED: if `s`=1, set `cnt`=1 and go to PRESS_PEND. If `DEBOUNCE_TICKS`=1, go directly to PRESSED instead.
  - PRESS_PEND:
    - `s`=0 → `cnt`=0, back to RELEASED.
    - `s`=1 and `cnt`+1 == `DEBOUNCE_TICKS` → go to PRESSED.
    - otherwise `cnt`++.
  - PRESSED, RELEASE_PEND: mirror of the above with `s` inverted; the release completes into RELEASED.
- `sw_level` = 1 in PRESSED and RELEASE_PEND, 0 otherwise. It is registered.
- `sw_press` is asserted for exactly one cycle in the cycle that follows the tick on which PRESS_PEND→PRESSED occurs. `sw_level` rises in that same cycle. `sw_release` behaves the same way for RELEASE_PEND→RELEASED.
- Channels are independent. Simultaneous events on several channels produce pulses in the same cycle.
- `cnt` never exceeds `DEBOUNCE_TICKS`. No wrap-around is possible.

## Timing
- Reset values:
  - all outputs 0
  - FSMs in RELEASED
  - `cnt` = 0
  - synchroniser bits 1
- `reset` asserted mid-PEND: the pending event is discarded and no pulse is emitted. After reset, the input is re-debounced from zero.
- Latency from a stable `sw_n` edge to the pulse is 2 sync cycles + between (`DEBOUNCE_TICKS`-1)·`TICK_DIV`+1 and `DEBOUNCE_TICKS`·`TICK_DIV`+1 cycles. At defaults this is about 19–20 ms.
- Minimum spacing between a press pulse and the next release pulse on a channel is `DEBOUNCE_TICKS` ticks.
- Glitches that are not sampled on a tick are invisible. Sampled glitches shorter than `DEBOUNCE_TICKS` ticks clear `cnt` and produce no pulse.

## Structure
- Shared package `slot_pkg` holds:
  - `NUM_SW` = 3
  - `DEF_TICK_DIV` = 6000
  - `DEF_DEBOUNCE_TICKS` = 20
  - the debounce state enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND)
- Sub-module `debounce_channel` contains one synchroniser, FSM, counter and pulse registers. It takes `tick` as an input and is instantiated `NUM_SW` times.
- The tick generator lives in the top and is shared by all channels.

## Test plan
All scenarios use `TICK_DIV`=4, `DEBOUNCE_TICKS`=3.
- Reset: hold `reset` 5 cycles with `sw_n`=000 → all outputs 0 throughout and in the cycle after release. The first press is accepted only after the full debounce.
- Clean press: `sw_n[0]` 1→0 and held → exactly one `sw_press[0]` pulse 11–15 cycles after the edge, and `sw_level[0]`=1 from that cycle. Then 0→1 → one `sw_release[0]` pulse with the same latency bound.
- Bounce: toggle `sw_n[1]` every 3 cycles for 40 cycles, then hold 0 → exactly one `sw_press[1]` pulse and no `sw_release[1]`.
- Glitch: a 1-cycle low on `sw_n[2]` aligned so it is sampled on a tick → `cnt` goes 1→0 and no pulses occur.
- Simultaneous: `sw_n` 111→000 in one cycle → `sw_press` = 111 in a single cycle, and `sw_level` = 111.
- Reset mid-operation: assert `reset` while channel 0 is in PRESS_PEND with `cnt`=2 → no pulse, `sw_level[0]`=0. With `sw_n[0]` still held low after reset, a press is accepted again after the full 11–15 cycle latency.
